// File: rtl/cafeteira_serial_tx.sv
// cafeteira_serial_tx: FIFO-buffered UART transmitter, 8N1 by default, 8E1 when PARITY_EN is defined.
module cafeteira_serial_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dados,
  output logic       txd,
  output logic       ocupado,
  output logic       cheio,
  output logic       pronto,
  output logic       descartado
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, count_n;
  logic [CW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic push, pop, last;
  always_comb begin
    push = partida && !cheio;
    pop = (state == IDLE) && (count != '0);
    count_n = count + (AW+1)'(push) - (AW+1)'(pop);
    last = baud == CW'(CLKS_PER_BIT - 1);
  end
  always_ff @(posedge clock) if (push) mem[wr_ptr] <= dados;
  // txd follows the state one cycle late, so every bit period lasts exactly CLKS_PER_BIT cycles on the line
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
      txd <= 1'b1;
      ocupado <= 1'b0;
      cheio <= 1'b0;
      pronto <= 1'b0;
      descartado <= 1'b0;
`ifdef PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      pronto <= 1'b0;
      descartado <= partida && cheio;
      count <= count_n;
      cheio <= count_n == (AW+1)'(FIFO_DEPTH);
      ocupado <= (count_n != '0) || (state != IDLE) || pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      baud <= last ? '0 : baud + CW'(1);
      case (state)
        IDLE: begin
          txd <= 1'b1;
          baud <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
`ifdef PARITY_EN
            par <= ^mem[rd_ptr];
`endif
            rd_ptr <= rd_ptr + AW'(1);
            state <= START;
          end
        end
        START: begin
          txd <= 1'b0;
          if (last) begin
            bit_idx <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          txd <= shift[0];
          if (last) begin
            shift <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
`ifdef PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          txd <= par;
          if (last) state <= STOP;
        end
`endif
        default: begin
          txd <= 1'b1;
          if (last) begin
            pronto <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
